// File: rtl/div_by_3_pkg.sv
// Shared types and constants for the divide-by-3 operand feeder:
// operand type, launch FSM states and the legal queue-depth range.
package div_by_3_pkg;

  typedef logic [15:0] operand_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int DEPTH_MIN     = 2;
  localparam int DEPTH_MAX     = 16;
  localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/div_by_3_fifo.sv
// Operand queue for the divide-by-3 feeder: power-of-two depth circular buffer
// with occupancy count and a synchronous flush that empties it in one edge.
module div_by_3_fifo
  import div_by_3_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  operand_t                 i_data,
  output operand_t                 o_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  operand_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [LW-1:0]   r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;

endmodule

// File: rtl/div_by_3_feeder.sv
// Queues operands and launches them one at a time into a divide-by-3 unit.
// Define DIV_BY_3_FEEDER_BYPASS_EN for a zero-latency launch when idle and empty.
module div_by_3_feeder
  import div_by_3_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_x,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     busy,
  output logic                     pass,
  output logic [15:0]              x,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t          r_state;
  logic            r_pass;
  operand_t        r_x;

  operand_t        w_head;
  logic [LW-1:0]   w_level;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_bypass;

  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == LW'(DEPTH));
  assign in_ready = ~w_full & ~flush;

`ifdef DIV_BY_3_FEEDER_BYPASS_EN
  assign w_bypass = (r_state == IDLE) & w_empty & ~busy & in_valid & ~flush;
  assign pass     = r_pass | w_bypass;
  assign x        = w_bypass ? in_x : r_x;
`else
  assign w_bypass = 1'b0;
  assign pass     = r_pass;
  assign x        = r_x;
`endif

  // A bypassed operand goes straight to the divider, never into the queue.
  assign w_push = in_valid & in_ready & ~w_bypass;
  assign w_pop  = ~w_empty & ~busy & ((r_state == IDLE) | (r_state == WAIT));

  div_by_3_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (in_x),
    .o_data  (w_head),
    .o_level (w_level)
  );

  assign level = w_level;

  // A flush in the same cycle as a pop still launches the popped head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pass  <= 1'b0;
      r_x     <= '0;
    end else begin
      r_pass <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_x     <= w_head;
            r_pass  <= 1'b1;
            r_state <= LAUNCH;
          end else if (w_bypass) begin
            r_x     <= in_x;
            r_state <= WAIT;
          end
        end
        LAUNCH: r_state <= WAIT;
        WAIT: begin
          if (w_pop) begin
            r_x     <= w_head;
            r_pass  <= 1'b1;
            r_state <= LAUNCH;
          end else if (!busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
